dnpcie_aurora_link_monitor: RTL

//  Watches Aurora link status after the reset sequencer releases gt_reset/chan_reset and decides when the link must be reset again.

---
 rtl/dnpcie_aurora_link_monitor.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dnpcie_aurora_link_monitor.sv
// Aurora link supervisor in the init_clk domain: watches bring-up and link health and requests sequencer resets.
// Optional soft-error rate trip is enabled by defining DNPCIE_AURORA_LINKMON_SOFTERR_EN.
module dnpcie_aurora_link_monitor #(
   parameter int unsigned LANES           = 4,
   parameter int unsigned UP_TIMEOUT      = 200000000,
   parameter int unsigned REQ_CYCLES      = 1024,
   parameter int unsigned HOLDOFF_MAX     = 400000000,
   parameter int unsigned SOFT_ERR_LIMIT  = 16,
   parameter int unsigned SOFT_ERR_WINDOW = 2000000
) (
   input  logic             init_clk,
   input  logic             init_rst_n,
   input  logic             gt_reset,
   input  logic             chan_reset,
   input  logic             channel_up,
   input  logic [LANES-1:0] lane_up,
   input  logic             hard_err,
   input  logic             soft_err,
   output logic             link_reset_req,
   output logic             link_ok,
   output logic [15:0]      retry_count,
   output logic [15:0]      soft_err_count,
   output logic [1:0]       last_cause
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_UP = 3'd1,
      UP      = 3'd2,
      REQ     = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
   localparam logic [1:0] CAUSE_LINK    = 2'd2;
   localparam logic [1:0] CAUSE_SOFT    = 2'd3;

   state_t           state;
   logic [31:0]      timer;

   logic             channel_up_m;
   logic             channel_up_s;
   logic [LANES-1:0] lane_up_m;
   logic [LANES-1:0] lane_up_s;
   logic             hard_err_m;
   logic             hard_err_s;

   logic             any_reset;
   logic             link_good;
   logic             link_fault;
   logic             soft_trip;

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   // user_clk status into init_clk: two flops per bit, cleared by reset
   always_ff @(posedge init_clk) begin
      if (!init_rst_n) begin
         channel_up_m <= 1'b0;
         channel_up_s <= 1'b0;
         lane_up_m    <= '0;
         lane_up_s    <= '0;
         hard_err_m   <= 1'b0;
         hard_err_s   <= 1'b0;
      end else begin
         channel_up_m <= channel_up;
         channel_up_s <= channel_up_m;
         lane_up_m    <= lane_up;
         lane_up_s    <= lane_up_m;
         hard_err_m   <= hard_err;
         hard_err_s   <= hard_err_m;
      end
   end

   assign any_reset  = gt_reset | chan_reset;
   assign link_good  = channel_up_s & (&lane_up_s);
   assign link_fault = ~link_good | hard_err_s;

`ifdef DNPCIE_AURORA_LINKMON_SOFTERR_EN
   logic        soft_err_m;
   logic        soft_err_s;
   logic        soft_err_d;
   logic        soft_rise;
   logic [31:0] win_timer;
   logic [31:0] win_count;
   logic [31:0] win_base;
   logic        win_end;

   assign soft_rise = soft_err_s & ~soft_err_d;
   assign win_end   = (win_timer == SOFT_ERR_WINDOW - 1);
   // an edge landing on the window boundary opens the next window
   assign win_base  = win_end ? 32'd0 : win_count;
   assign soft_trip = soft_rise && (win_base + 32'd1 >= SOFT_ERR_LIMIT);

   always_ff @(posedge init_clk) begin
      if (!init_rst_n) begin
         soft_err_m     <= 1'b0;
         soft_err_s     <= 1'b0;
         soft_err_d     <= 1'b0;
         soft_err_count <= 16'd0;
         win_timer      <= 32'd0;
         win_count      <= 32'd0;
      end else begin
         soft_err_m <= soft_err;
         soft_err_s <= soft_err_m;
         soft_err_d <= soft_err_s;
         if (soft_rise) begin
            soft_err_count <= sat_inc(soft_err_count);
         end
         if (state != UP) begin
            win_timer <= 32'd0;
            win_count <= 32'd0;
         end else begin
            win_timer <= win_end ? 32'd0 : win_timer + 32'd1;
            win_count <= win_base + {31'd0, soft_rise};
         end
      end
   end
`else
   logic unused_soft_err;

   assign unused_soft_err = soft_err;
   assign soft_trip       = 1'b0;
   assign soft_err_count  = 16'd0;
`endif

   // supervisor FSM; link_ok and link_reset_req are registered alongside the state
   always_ff @(posedge init_clk) begin
      if (!init_rst_n) begin
         state          <= IDLE;
         timer          <= 32'd0;
         link_reset_req <= 1'b0;
         link_ok        <= 1'b0;
         retry_count    <= 16'd0;
         last_cause     <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!any_reset) begin
                  state <= WAIT_UP;
                  timer <= 32'd0;
               end
            end
            WAIT_UP: begin
               if (any_reset) begin
                  state <= IDLE;
                  timer <= 32'd0;
               end else if (link_good) begin
                  state   <= UP;
                  timer   <= 32'd0;
                  link_ok <= 1'b1;
               end else if (timer == UP_TIMEOUT - 1) begin
                  state          <= REQ;
                  timer          <= 32'd0;
                  link_reset_req <= 1'b1;
                  retry_count    <= sat_inc(retry_count);
                  last_cause     <= CAUSE_TIMEOUT;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            UP: begin
               if (any_reset) begin
                  state   <= IDLE;
                  timer   <= 32'd0;
                  link_ok <= 1'b0;
               end else if (link_fault || soft_trip) begin
                  state          <= REQ;
                  timer          <= 32'd0;
                  link_ok        <= 1'b0;
                  link_reset_req <= 1'b1;
                  retry_count    <= sat_inc(retry_count);
                  last_cause     <= link_fault ? CAUSE_LINK : CAUSE_SOFT;
               end
            end
            REQ: begin
               if (timer == REQ_CYCLES - 1) begin
                  state          <= HOLDOFF;
                  timer          <= 32'd0;
                  link_reset_req <= 1'b0;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            HOLDOFF: begin
               if (gt_reset) begin
                  state <= IDLE;
                  timer <= 32'd0;
               end else if (timer == HOLDOFF_MAX - 1) begin
                  // sequencer never reacted: ask again with the same cause
                  state          <= REQ;
                  timer          <= 32'd0;
                  link_reset_req <= 1'b1;
                  retry_count    <= sat_inc(retry_count);
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            default: begin
               state          <= IDLE;
               timer          <= 32'd0;
               link_ok        <= 1'b0;
               link_reset_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
